dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the bus-wait cycle count (ADDR+DATA states) at which timeout asserts.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 req_valid  in  1  MEM-stage load/store request.
REQ-005 req_we  in  1  1=store, 0=load.
REQ-006 req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-007 req_unsigned  in  1  load zero-extend (1) or sign-extend (0).
REQ-008 req_addr  in  32  byte address.
REQ-009 req_wdata  in  32  store data, right-justified.
REQ-010 req_ready  out  1  high only in IDLE; request accepted when req_valid&&req_ready.
REQ-011 resp_valid  out  1  one-cycle completion pulse.
REQ-012 resp_rdata  out  32  extended load data, valid with resp_valid; 0 for stores/errors.
REQ-013 addr_err  out  1  one-cycle pulse, misaligned or illegal-size request.
REQ-014 stallreq  out  1  pipeline stall request to the stall controller.
REQ-015 timeout  out  1  sticky bus-timeout flag.
REQ-016 data_sram_req, data_sram_wr  out  1 each  bus request, write qualifier.
REQ-017 data_sram_wen  out  4  byte lane enables; data_sram_addr, data_sram_wdata  out  32 each.
REQ-018 data_sram_addr_ok, data_sram_data_ok  in  1 each; data_sram_rdata  in  32.

Function
REQ-019 FSM states SHALL be IDLE, ADDR, DATA, RESP.
REQ-020 IDLE: on req_valid with legal aligned request, latch all req_* fields and go to ADDR next cycle.
REQ-021 Misaligned = half with addr[0]=1, word with addr[1:0]!=0, or size=11; SHALL pulse addr_err and resp_valid (resp_rdata=0) the next cycle, stay IDLE, no bus activity.
REQ-022 ADDR: data_sram_req=1 with addr/wr/wen/wdata held stable until addr_ok; on addr_ok go to DATA, req deasserted from next cycle.
REQ-023 DATA: on data_ok register resp_rdata and go to RESP; data_ok in the same cycle as addr_ok SHALL be ignored (earliest accepted data_ok is first DATA cycle).
REQ-024 RESP: resp_valid=1 for exactly one cycle, then IDLE; req_ready=0 in RESP.
REQ-025 Minimum accepted-to-resp_valid latency SHALL be 3 cycles (addr_ok and data_ok each one cycle after the prior state entry).
REQ-026 data_sram_addr SHALL be {addr[31:2],2'b00}; data_sram_wr=req_we.
REQ-027 Store lanes (little-endian): byte wen=0001<<addr[1:0], wdata={4{b[7:0]}}; half wen=0011 (addr[1]=0) or 1100, wdata={2{h[15:0]}}; word wen=1111, wdata=req_wdata.
REQ-028 Loads SHALL drive wen=0000 and wdata=0.
REQ-029 Load extraction: byte rdata[8*a+7:8*a], half rdata[16*addr[1]+15:16*addr[1]], extended per req_unsigned; word unmodified.
REQ-030 stallreq SHALL be 1 in ADDR and DATA, and in IDLE when req_valid with a legal aligned request; 0 in RESP and otherwise.
REQ-031 Wait counter SHALL clear on entry to ADDR, increment each ADDR/DATA cycle, saturate; at TIMEOUT_CYCLES set timeout (sticky until reset); FSM continues waiting.
REQ-032 data_ok or addr_ok received in IDLE or RESP SHALL be ignored.
REQ-033 Back-to-back requests SHALL be accepted in the IDLE cycle following RESP.

Reset
REQ-034 rst SHALL asynchronously force IDLE, clear latched fields, wait counter and timeout, and drive every output to 0 except req_ready=1.
REQ-035 rst mid-transaction SHALL drop data_sram_req immediately; a stale data_ok after reset release SHALL not produce resp_valid.

Verification
REQ-036 Word load addr 0x100, addr_ok/data_ok immediate, rdata 0x8899AABB -> resp_valid cycle 3 after accept, resp_rdata 0x8899AABB, wen 0000.
REQ-037 lb signed addr 0x103, rdata 0x80112233 -> resp_rdata 0xFFFFFF80; lbu same -> 0x00000080.
REQ-038 sh addr 0x202, wdata 0x0000BEEF -> data_sram_addr 0x200, wen 1100, wdata 0xBEEFBEEF, resp_rdata 0.
REQ-039 lw addr 0x101 -> addr_err and resp_valid pulse next cycle, data_sram_req never asserts, stallreq 0.
REQ-040 TIMEOUT_CYCLES=4, addr_ok withheld 10 cycles -> timeout rises after 4 wait cycles, stays high, transaction completes normally; rst in DATA -> all outputs reset, later data_ok ignored.

Source files
------------

// File: rtl/dmem_ctrl.sv
// Data-memory access controller: turns MEM-stage load/store requests into
// SRAM-like bus transactions (address phase, then data phase) with lane steering.
module dmem_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        addr_err,
    output logic        stallreq,
    output logic        timeout,
    output logic        data_sram_req,
    output logic        data_sram_wr,
    output logic [3:0]  data_sram_wen,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic        data_sram_addr_ok,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata
);
    localparam int CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t        state_reg;
    logic          we_reg;
    logic          uns_reg;
    logic [1:0]    size_reg;
    logic [31:0]   addr_reg;
    logic [31:0]   wdata_reg;
    logic [CW-1:0] wait_reg;
    logic          timeout_reg;
    logic          err_reg;
    logic [31:0]   rdata_reg;

    logic          misaligned;
    logic          accept;
    logic [3:0]    lane_wen;
    logic [31:0]   lane_wdata;
    logic [31:0]   load_data;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [7:0]    rd_bytes [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bytes
            assign rd_bytes[gi] = data_sram_rdata[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        misaligned = (req_size == 2'b11)
                  || (req_size == 2'b01 && req_addr[0])
                  || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
        accept     = (state_reg == IDLE) && req_valid && !misaligned;
    end

    // Store lanes are derived from the latched request so they stay stable in ADDR.
    always_comb begin
        lane_wen   = 4'b0000;
        lane_wdata = 32'b0;
        if (we_reg) begin
            case (size_reg)
                2'b00: begin
                    lane_wen   = 4'b0001 << addr_reg[1:0];
                    lane_wdata = {4{wdata_reg[7:0]}};
                end
                2'b01: begin
                    lane_wen   = addr_reg[1] ? 4'b1100 : 4'b0011;
                    lane_wdata = {2{wdata_reg[15:0]}};
                end
                default: begin
                    lane_wen   = 4'b1111;
                    lane_wdata = wdata_reg;
                end
            endcase
        end
    end

    always_comb begin
        byte_sel  = rd_bytes[addr_reg[1:0]];
        half_sel  = addr_reg[1] ? data_sram_rdata[31:16] : data_sram_rdata[15:0];
        load_data = 32'b0;
        if (!we_reg) begin
            case (size_reg)
                2'b00:   load_data = {{24{!uns_reg && byte_sel[7]}}, byte_sel};
                2'b01:   load_data = {{16{!uns_reg && half_sel[15]}}, half_sel};
                default: load_data = data_sram_rdata;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            we_reg      <= 1'b0;
            uns_reg     <= 1'b0;
            size_reg    <= 2'b00;
            addr_reg    <= 32'b0;
            wdata_reg   <= 32'b0;
            wait_reg    <= '0;
            timeout_reg <= 1'b0;
            err_reg     <= 1'b0;
            rdata_reg   <= 32'b0;
        end else begin
            err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req_valid && misaligned) begin
                        err_reg <= 1'b1;
                    end else if (accept) begin
                        we_reg    <= req_we;
                        uns_reg   <= req_unsigned;
                        size_reg  <= req_size;
                        addr_reg  <= req_addr;
                        wdata_reg <= req_wdata;
                        wait_reg  <= '0;
                        state_reg <= ADDR;
                    end
                end
                ADDR, DATA: begin
                    // Timeout only flags a slow bus; the transaction keeps waiting.
                    if (int'(wait_reg) < TIMEOUT_CYCLES)
                        wait_reg <= wait_reg + 1'b1;
                    if (int'(wait_reg) + 1 >= TIMEOUT_CYCLES)
                        timeout_reg <= 1'b1;
                    if (state_reg == ADDR) begin
                        if (data_sram_addr_ok)
                            state_reg <= DATA;
                    end else if (data_sram_data_ok) begin
                        rdata_reg <= load_data;
                        state_reg <= RESP;
                    end
                end
                default: begin
                    rdata_reg <= 32'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        req_ready       = (state_reg == IDLE);
        resp_valid      = (state_reg == RESP) || err_reg;
        resp_rdata      = rdata_reg;
        addr_err        = err_reg;
        stallreq        = (state_reg == ADDR) || (state_reg == DATA) || accept;
        timeout         = timeout_reg;
        data_sram_req   = (state_reg == ADDR);
        data_sram_wr    = (state_reg == ADDR) && we_reg;
        data_sram_wen   = (state_reg == ADDR) ? lane_wen : 4'b0000;
        data_sram_addr  = (state_reg == ADDR) ? {addr_reg[31:2], 2'b00} : 32'b0;
        data_sram_wdata = (state_reg == ADDR) ? lane_wdata : 32'b0;
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed vector table, timeout/reset sequences and
// randomized transactions checked against an arithmetic reference model.
module tb_dmem_ctrl;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, addr_err, stallreq, timeout;
    logic [31:0] resp_rdata;
    logic        data_sram_req, data_sram_wr;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .addr_err(addr_err), .stallreq(stallreq), .timeout(timeout),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_wen(data_sram_wen), .data_sram_addr(data_sram_addr),
        .data_sram_wdata(data_sram_wdata), .data_sram_addr_ok(data_sram_addr_ok),
        .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata)
    );

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        logic [3:0]  wen;
        logic [31:0] wdata;
    } exp_t;

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ad;
        int          dd;
        bit          early;
        logic        e_err;
        logic [31:0] e_rdata;
        logic [3:0]  e_wen;
        logic [31:0] e_wdata;
        int          e_lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: little-endian lane rules expressed with shifts, masks and multiplies.
    function automatic exp_t model(input logic we, input logic [1:0] size, input logic uns,
                                   input logic [31:0] addr, input logic [31:0] wdata,
                                   input logic [31:0] rdata);
        exp_t e;
        int lane;
        logic [31:0] sh;
        lane = int'(addr % 4);
        e.err = 1'b0; e.rdata = 32'b0; e.wen = 4'b0; e.wdata = 32'b0;
        e.err = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && lane != 0);
        if (e.err) return e;
        if (we) begin
            case (size)
                2'd0: begin e.wen = 4'(1 << lane); e.wdata = (wdata & 32'hFF) * 32'h01010101; end
                2'd1: begin e.wen = (lane >= 2) ? 4'hC : 4'h3; e.wdata = (wdata & 32'hFFFF) * 32'h00010001; end
                default: begin e.wen = 4'hF; e.wdata = wdata; end
            endcase
        end else begin
            sh = rdata >> (8 * lane);
            case (size)
                2'd0: e.rdata = (uns || !sh[7]) ? (sh & 32'hFF) : (sh | 32'hFFFFFF00);
                2'd1: e.rdata = (uns || !sh[15]) ? (sh & 32'hFFFF) : (sh | 32'hFFFF0000);
                default: e.rdata = rdata;
            endcase
        end
        return e;
    endfunction

    // Issues one request at posedge+1 and acts as the bus; ad/dd are the number of
    // cycles addr_ok/data_ok are withheld. early also raises data_ok during ADDR.
    task automatic run_txn(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int ad, input int dd, input bit early,
                           output int lat, output logic [31:0] got_rdata, output logic got_err,
                           output logic [3:0] got_wen, output logic [31:0] got_addr,
                           output logic [31:0] got_wdata, output logic got_wr,
                           output int req_cycles, output int tmo_cyc,
                           output logic acc_stall, output logic acc_ready);
        bit adone = 0, ddone = 0;
        int rc = 0, dc = 0;
        lat = -1; got_rdata = '0; got_err = 0; got_wen = '0; got_addr = '0;
        got_wdata = '0; got_wr = 0; req_cycles = 0; tmo_cyc = -1;
        req_valid = 1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; data_sram_rdata = rdata;
        data_sram_addr_ok = 0; data_sram_data_ok = 0;
        @(negedge clk);
        acc_stall = stallreq; acc_ready = req_ready;
        @(posedge clk); #1;
        req_valid = 0; req_wdata = $urandom; req_addr = $urandom;
        for (int cyc = 1; cyc <= 60 && lat < 0; cyc++) begin
            data_sram_addr_ok = data_sram_req && !adone && rc >= ad;
            data_sram_data_ok = (early && !adone) || (adone && !ddone && dc >= dd);
            @(negedge clk);
            if (data_sram_req) begin
                req_cycles++;
                got_wen = data_sram_wen; got_addr = data_sram_addr;
                got_wdata = data_sram_wdata; got_wr = data_sram_wr;
            end
            if (timeout && tmo_cyc < 0) tmo_cyc = cyc;
            if (resp_valid) begin
                lat = cyc; got_rdata = resp_rdata; got_err = addr_err;
            end
            if (adone && data_sram_data_ok) ddone = 1;
            else if (adone) dc++;
            if (data_sram_addr_ok) adone = 1;
            else if (data_sram_req) rc++;
            @(posedge clk); #1;
        end
        data_sram_addr_ok = 0; data_sram_data_ok = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
    endtask

    vec_t        vecs [12];
    int          lat, rq, tcyc;
    logic [31:0] g_rd, g_addr, g_wd;
    logic        g_err, g_wr, a_stall, a_ready;
    logic [3:0]  g_wen;

    initial begin
        rst = 1; req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0;
        req_addr = 0; req_wdata = 0; data_sram_addr_ok = 0; data_sram_data_ok = 0;
        data_sram_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_addr_err", {31'b0, addr_err}, 32'd0);
        chk("rst_stallreq", {31'b0, stallreq}, 32'd0);
        chk("rst_timeout", {31'b0, timeout}, 32'd0);
        chk("rst_sram_req", {31'b0, data_sram_req}, 32'd0);
        chk("rst_sram_outs", {data_sram_wr, data_sram_wen, 27'b0} | data_sram_addr | data_sram_wdata | resp_rdata, 32'd0);
        rst = 0;

        vecs[0]  = '{"lw_100",   0, 2'd2, 0, 32'h100, 32'h0,        32'h8899AABB, 0, 0, 0, 0, 32'h8899AABB, 4'h0, 32'h0,        3};
        vecs[1]  = '{"lb_103",   0, 2'd0, 0, 32'h103, 32'h0,        32'h80112233, 0, 0, 0, 0, 32'hFFFFFF80, 4'h0, 32'h0,        3};
        vecs[2]  = '{"lbu_103",  0, 2'd0, 1, 32'h103, 32'h0,        32'h80112233, 0, 0, 0, 0, 32'h00000080, 4'h0, 32'h0,        3};
        vecs[3]  = '{"sh_202",   1, 2'd1, 0, 32'h202, 32'h0000BEEF, 32'h12345678, 0, 0, 0, 0, 32'h0,        4'hC, 32'hBEEFBEEF, 3};
        vecs[4]  = '{"lw_101",   0, 2'd2, 0, 32'h101, 32'h0,        32'h12345678, 0, 0, 0, 1, 32'h0,        4'h0, 32'h0,        1};
        vecs[5]  = '{"sb_101",   1, 2'd0, 0, 32'h101, 32'h123456A5, 32'h0,        1, 0, 0, 0, 32'h0,        4'h2, 32'hA5A5A5A5, 4};
        vecs[6]  = '{"lh_102",   0, 2'd1, 0, 32'h102, 32'h0,        32'h9ABC1234, 0, 1, 0, 0, 32'hFFFF9ABC, 4'h0, 32'h0,        4};
        vecs[7]  = '{"lhu_100",  0, 2'd1, 1, 32'h100, 32'h0,        32'h9ABC8234, 0, 0, 1, 0, 32'h00008234, 4'h0, 32'h0,        3};
        vecs[8]  = '{"sw_10c",   1, 2'd2, 0, 32'h10C, 32'hDEADBEEF, 32'hFFFFFFFF, 1, 0, 1, 0, 32'h0,        4'hF, 32'hDEADBEEF, 4};
        vecs[9]  = '{"sz11_200", 0, 2'd3, 0, 32'h200, 32'h0,        32'h0,        0, 0, 0, 1, 32'h0,        4'h0, 32'h0,        1};
        vecs[10] = '{"sh_201",   1, 2'd1, 0, 32'h201, 32'h1111,     32'h0,        0, 0, 0, 1, 32'h0,        4'h0, 32'h0,        1};
        vecs[11] = '{"lb_100",   0, 2'd0, 0, 32'h100, 32'h0,        32'h0000007F, 0, 0, 0, 0, 32'h0000007F, 4'h0, 32'h0,        3};

        @(posedge clk); #1;
        foreach (vecs[i]) begin
            run_txn(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                    vecs[i].rdata, vecs[i].ad, vecs[i].dd, vecs[i].early,
                    lat, g_rd, g_err, g_wen, g_addr, g_wd, g_wr, rq, tcyc, a_stall, a_ready);
            $display("vec %s lat=%0d rdata=%h err=%0d wen=%h wdata=%h", vecs[i].name, lat, g_rd, g_err, g_wen, g_wd);
            chk({vecs[i].name, "_lat"}, lat, vecs[i].e_lat);
            chk({vecs[i].name, "_rdata"}, g_rd, vecs[i].e_rdata);
            chk({vecs[i].name, "_err"}, {31'b0, g_err}, {31'b0, vecs[i].e_err});
            chk({vecs[i].name, "_wen"}, {28'b0, g_wen}, {28'b0, vecs[i].e_wen});
            chk({vecs[i].name, "_wdata"}, g_wd, vecs[i].e_wdata);
            chk({vecs[i].name, "_addr"}, g_addr, vecs[i].e_err ? 32'h0 : (vecs[i].addr & ~32'h3));
            chk({vecs[i].name, "_wr"}, {31'b0, g_wr}, vecs[i].e_err ? 32'h0 : {31'b0, vecs[i].we});
            chk({vecs[i].name, "_reqcyc"}, rq, vecs[i].e_err ? 0 : vecs[i].ad + 1);
            chk({vecs[i].name, "_stall"}, {31'b0, a_stall}, {31'b0, !vecs[i].e_err});
            chk({vecs[i].name, "_ready"}, {31'b0, a_ready}, 32'd1);
        end

        // Slow address phase: timeout after four wait cycles, then normal completion.
        do_reset();
        run_txn(0, 2'd2, 0, 32'h300, 32'h0, 32'hCAFEF00D, 10, 0, 0,
                lat, g_rd, g_err, g_wen, g_addr, g_wd, g_wr, rq, tcyc, a_stall, a_ready);
        $display("timeout txn lat=%0d tmo_cycle=%0d rdata=%h", lat, tcyc, g_rd);
        chk("tmo_rise_cycle", tcyc, 5);
        chk("tmo_lat", lat, 13);
        chk("tmo_rdata", g_rd, 32'hCAFEF00D);
        run_txn(1, 2'd2, 0, 32'h304, 32'h5, 32'h0, 0, 0, 0,
                lat, g_rd, g_err, g_wen, g_addr, g_wd, g_wr, rq, tcyc, a_stall, a_ready);
        chk("tmo_sticky", tcyc, 1);

        // Reset in DATA; a stale data_ok afterwards must not complete anything.
        do_reset();
        chk("tmo_cleared", {31'b0, timeout}, 32'd0);
        req_valid = 1; req_we = 0; req_size = 2'd2; req_addr = 32'h100; req_unsigned = 0;
        data_sram_addr_ok = 1; data_sram_data_ok = 1;
        @(posedge clk); #1;
        req_valid = 0; data_sram_data_ok = 0;
        @(posedge clk); #1;
        data_sram_addr_ok = 0;
        chk("data_state_stall", {31'b0, stallreq}, 32'd1);
        #2 rst = 1;
        #1;
        chk("async_rst_req", {31'b0, data_sram_req}, 32'd0);
        chk("async_rst_ready", {31'b0, req_ready}, 32'd1);
        chk("async_rst_stall", {31'b0, stallreq}, 32'd0);
        rst = 0;
        data_sram_data_ok = 1;
        rq = 0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid || data_sram_req) rq++;
        end
        data_sram_data_ok = 0;
        $display("stale data_ok after reset: spurious=%0d", rq);
        chk("stale_data_ok", rq, 0);

        // Randomized traffic against the model.
        do_reset();
        begin
            logic        we, uns, exp_tmo;
            logic [1:0]  size;
            logic [31:0] addr, wdata, rdata;
            int          ad, dd;
            bit          early;
            exp_t        e;
            exp_tmo = 0;
            for (int n = 0; n < 40; n++) begin
                we = 1'($urandom); uns = 1'($urandom); size = 2'($urandom_range(0, 3));
                addr = $urandom & 32'hFFF; wdata = $urandom; rdata = $urandom;
                if ($urandom_range(0, 3) != 0)
                    addr = addr & ~((size == 2'd2) ? 32'h3 : (size == 2'd1) ? 32'h1 : 32'h0);
                ad = $urandom_range(0, 2); dd = $urandom_range(0, 2); early = 1'($urandom);
                e = model(we, size, uns, addr, wdata, rdata);
                if (!e.err && ad + dd + 2 >= TMO) exp_tmo = 1;
                run_txn(we, size, uns, addr, wdata, rdata, ad, dd, early,
                        lat, g_rd, g_err, g_wen, g_addr, g_wd, g_wr, rq, tcyc, a_stall, a_ready);
                $display("rnd %0d we=%0d sz=%0d a=%h lat=%0d rd=%h err=%0d wen=%h wd=%h", n, we, size, addr, lat, g_rd, g_err, g_wen, g_wd);
                chk("rnd_lat", lat, e.err ? 1 : ad + dd + 3);
                chk("rnd_rdata", g_rd, e.rdata);
                chk("rnd_err", {31'b0, g_err}, {31'b0, e.err});
                chk("rnd_wen", {28'b0, g_wen}, {28'b0, e.wen});
                chk("rnd_wdata", g_wd, e.wdata);
                chk("rnd_addr", g_addr, e.err ? 32'h0 : (addr & ~32'h3));
                chk("rnd_timeout", {31'b0, timeout}, {31'b0, exp_tmo});
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
